// File: rtl/xor_parity_checker_if.sv
// Serial-in / parallel-out bus of the XOR parity checker.
// master = serial source plus the downstream consumer; slave = the checker.
interface xor_parity_checker_if #(
    parameter int unsigned DATA_W = 8
);
    logic              bit_in;
    logic              bit_valid;
    logic              clear;
    logic [DATA_W-1:0] data_out;
    logic              frame_done;
    logic              parity_err;
    logic              busy;

    modport master (
        output bit_in,
        output bit_valid,
        output clear,
        input  data_out,
        input  frame_done,
        input  parity_err,
        input  busy
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        input  clear,
        output data_out,
        output frame_done,
        output parity_err,
        output busy
    );
endinterface

// File: rtl/xor_parity_checker.sv
// Receive-side serial parity checker.
// Collects DATA_W data bits LSB-first plus one parity bit. It then presents
// the parallel word and a parity verdict, with a one-cycle frame_done strobe.
module xor_parity_checker #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ODD    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    xor_parity_checker_if.slave  bus
);
    localparam int unsigned      CNT_W     = $clog2(DATA_W + 1);
    localparam logic             ODD_BIT   = (ODD != 0);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            shift_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and datapath update; clear overrides a same-cycle bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        shift_d = shift_q;
        data_d  = data_q;
        err_d   = err_q;
        done_d  = 1'b0;

        if (bus.clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = 1'b0;
            shift_d = '0;
        end else if (bus.bit_valid) begin
            unique case (state_q)
                IDLE: begin
                    shift_d[0] = bus.bit_in;
                    acc_d      = bus.bit_in;
                    cnt_d      = CNT_W'(1);
                    state_d    = (DATA_W == 1) ? PAR : DATA;
                end
                DATA: begin
                    for (int unsigned i = 0; i < DATA_W; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            shift_d[i] = bus.bit_in;
                        end
                    end
                    acc_d = acc_q ^ bus.bit_in;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_DATA) begin
                        state_d = PAR;
                    end
                end
                PAR: begin
                    data_d  = shift_q;
                    err_d   = acc_q ^ bus.bit_in ^ ODD_BIT;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign bus.data_out   = data_q;
    assign bus.frame_done = done_q;
    assign bus.parity_err = err_q;
    assign bus.busy       = busy_q;
endmodule
